// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, response and memory-port signals of the two-port memory arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              clear;
    logic              req_valid_0, req_valid_1;
    logic              req_we_0, req_we_1;
    logic [ADDR_W-1:0] req_addr_0, req_addr_1;
    logic [DATA_W-1:0] req_wdata_0, req_wdata_1;
    logic              req_ready_0, req_ready_1;
    logic              resp_valid_0, resp_valid_1;
    logic [DATA_W-1:0] resp_rdata;
    logic              init_done;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_write_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [ADDR_W-1:0] mem_read_address;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  clear, req_valid_0, req_valid_1, req_we_0, req_we_1,
               req_addr_0, req_addr_1, req_wdata_0, req_wdata_1, mem_read_data,
        output req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_rdata,
               init_done, mem_write_en, mem_write_address, mem_write_data, mem_read_address
    );

    modport master (
        output clear, req_valid_0, req_valid_1, req_we_0, req_we_1,
               req_addr_0, req_addr_1, req_wdata_0, req_wdata_1, mem_read_data,
        input  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_rdata,
               init_done, mem_write_en, mem_write_address, mem_write_data, mem_read_address
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: initialises a shared memory, then round-robin arbitrates two requesters onto it.
module mem_arbiter #(
    parameter int                ADDR_W     = 5,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    typedef enum logic {INIT, RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic [1:0]        rvld_q, rvld_d;
    logic              run, g0, g1, gwe, grd;
    logic [ADDR_W-1:0] gaddr;
    logic [DATA_W-1:0] gdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            rvld_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            rvld_q  <= rvld_d;
        end
    end

    // rr_q names the requester that wins a tie; pending reads survive clear
    always_comb begin
        state_d = state_q;
        if (state_q == INIT && cnt_q == '1)
            state_d = RUN;
        else if (state_q == RUN && bus.clear)
            state_d = INIT;
        cnt_d  = run ? '0 : cnt_q + 1'b1;
        rr_d   = g0 ? 1'b1 : g1 ? 1'b0 : rr_q;
        rvld_d = {g1 & ~bus.req_we_1, g0 & ~bus.req_we_0};
    end

    always_comb begin
        run   = state_q == RUN;
        g0    = run & bus.req_valid_0 & (~bus.req_valid_1 | ~rr_q);
        g1    = run & bus.req_valid_1 & (~bus.req_valid_0 | rr_q);
        gwe   = g0 ? bus.req_we_0 : g1 & bus.req_we_1;
        grd   = (g0 | g1) & ~gwe;
        gaddr = g1 ? bus.req_addr_1 : bus.req_addr_0;
        gdata = g1 ? bus.req_wdata_1 : bus.req_wdata_0;
        bus.req_ready_0       = g0;
        bus.req_ready_1       = g1;
        bus.init_done         = run;
        bus.mem_write_en      = ~run | gwe;
        bus.mem_write_address = ~run ? cnt_q : gwe ? gaddr : '0;
        bus.mem_write_data    = ~run ? INIT_VALUE : gwe ? gdata : '0;
        bus.mem_read_address  = grd ? gaddr : '0;
        bus.resp_valid_0      = rvld_q[0];
        bus.resp_valid_1      = rvld_q[1];
        bus.resp_rdata        = |rvld_q ? bus.mem_read_data : '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a behavioural model.
module tb_mem_arbiter;
    localparam logic [7:0] INITV = 8'h00;

    logic clk = 0;
    logic rst = 1;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();
    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .INIT_VALUE(INITV)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // registered-read memory, read-before-write on the same address
    logic [7:0] tmem [32];
    always_ff @(posedge clk) begin
        if (bus.mem_write_en) tmem[bus.mem_write_address] <= bus.mem_write_data;
        bus.mem_read_data <= tmem[bus.mem_read_address];
    end

    // reference model state
    bit       m_run;
    int       m_cnt;
    int       m_fav;
    bit       m_pend;
    int       m_who;
    bit [7:0] m_data;
    bit [7:0] m_mem [32];

    task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, got, exp);
        end
    endtask

    task automatic drive(input bit v0, w0, input int a0, input int d0,
                         input bit v1, w1, input int a1, input int d1);
        bus.req_valid_0 = v0; bus.req_we_0 = w0; bus.req_addr_0 = 5'(a0); bus.req_wdata_0 = 8'(d0);
        bus.req_valid_1 = v1; bus.req_we_1 = w1; bus.req_addr_1 = 5'(a1); bus.req_wdata_1 = 8'(d1);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // checks every output against the model for this cycle, then advances the model past the clock edge
    task automatic tick();
        int       who;
        bit       g, wr;
        int       a;
        bit [7:0] d;
        #1;
        g   = m_run && (bus.req_valid_0 || bus.req_valid_1);
        who = (bus.req_valid_0 && bus.req_valid_1) ? m_fav : (bus.req_valid_1 ? 1 : 0);
        wr  = g && (who == 1 ? bus.req_we_1 : bus.req_we_0);
        a   = who == 1 ? int'(bus.req_addr_1) : int'(bus.req_addr_0);
        d   = who == 1 ? bus.req_wdata_1 : bus.req_wdata_0;
        cmp("req_ready_0", bus.req_ready_0, g && who == 0);
        cmp("req_ready_1", bus.req_ready_1, g && who == 1);
        cmp("init_done", bus.init_done, m_run);
        cmp("mem_write_en", bus.mem_write_en, !m_run || wr);
        cmp("mem_write_address", bus.mem_write_address, !m_run ? m_cnt : wr ? a : 0);
        cmp("mem_write_data", bus.mem_write_data, !m_run ? INITV : wr ? d : 0);
        cmp("mem_read_address", bus.mem_read_address, (g && !wr) ? a : 0);
        cmp("resp_valid_0", bus.resp_valid_0, m_pend && m_who == 0);
        cmp("resp_valid_1", bus.resp_valid_1, m_pend && m_who == 1);
        cmp("resp_rdata", bus.resp_rdata, m_pend ? m_data : 0);
        if (rst) begin
            m_run = 0; m_cnt = 0; m_fav = 0; m_pend = 0;
        end else begin
            m_pend = g && !wr;
            m_who  = who;
            m_data = m_mem[a];
            if (g) begin
                m_fav = 1 - who;
                if (wr) m_mem[a] = d;
            end
            if (!m_run) begin
                m_mem[m_cnt] = INITV;
                if (m_cnt == 31) m_run = 1; else m_cnt++;
            end else if (bus.clear) begin
                m_run = 0; m_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        bus.clear = 0;
        repeat (2) @(negedge clk);
        m_run = 0; m_cnt = 0; m_fav = 0; m_pend = 0;
        tick();
        rst = 0;
        // initialisation sweep after reset
        for (int i = 0; i < 32; i++) begin
            #1;
            cmp("init_addr", bus.mem_write_address, i);
            cmp("init_we", bus.mem_write_en, 1);
            cmp("init_low", bus.init_done, 0);
            tick();
        end
        #1 cmp("init_done_33", bus.init_done, 1);
        drive(1, 0, 31, 0, 0, 0, 0, 0);
        tick();
        idle();
        #1 cmp("rd31_valid", bus.resp_valid_0, 1);
        cmp("rd31_data", bus.resp_rdata, 8'h00);
        // write then immediate read of the same address
        drive(1, 1, 3, 8'hA5, 0, 0, 0, 0);
        tick();
        drive(1, 0, 3, 0, 0, 0, 0, 0);
        tick();
        idle();
        #1 cmp("wr_rd_valid", bus.resp_valid_0, 1);
        cmp("wr_rd_data", bus.resp_rdata, 8'hA5);
        drive(1, 1, 1, 8'h3B, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 1, 2, 8'h5C);
        tick();
        // contending reads alternate starting with requester 0
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 1, 0, 1, 0, 2, 0);
            #1 cmp("alt_ready_0", bus.req_ready_0, (i % 2) == 0);
            if (i > 0) cmp("alt_rdata", bus.resp_rdata, (i % 2) ? 8'h3B : 8'h5C);
            tick();
        end
        idle();
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 0, 2, 0);
            #1 cmp("solo_ready_1", bus.req_ready_1, 1);
            tick();
        end
        drive(1, 0, 1, 0, 1, 0, 2, 0);
        #1 cmp("rr_back_to_0", bus.req_ready_0, 1);
        tick();
        idle();
        tick();
        // read granted together with clear still responds
        drive(1, 1, 4, 8'h77, 0, 0, 0, 0);
        tick();
        drive(1, 0, 4, 0, 0, 0, 0, 0);
        bus.clear = 1;
        tick();
        idle();
        bus.clear = 0;
        #1 cmp("clr_resp_valid", bus.resp_valid_0, 1);
        cmp("clr_resp_data", bus.resp_rdata, 8'h77);
        cmp("clr_init", bus.init_done, 0);
        repeat (32) tick();
        #1 cmp("clr_reinit_done", bus.init_done, 1);
        drive(1, 0, 4, 0, 0, 0, 0, 0);
        tick();
        idle();
        #1 cmp("clr_rd4_data", bus.resp_rdata, 8'h00);
        // reset in the middle of initialisation
        rst = 1;
        tick();
        rst = 0;
        repeat (10) tick();
        #1 cmp("mid_init_addr", bus.mem_write_address, 10);
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            bus.clear = (i == 5);
            #1 cmp("reinit_low", bus.init_done, 0);
            cmp("reinit_addr", bus.mem_write_address, i);
            tick();
        end
        bus.clear = 0;
        #1 cmp("reinit_done", bus.init_done, 1);
        // random traffic with occasional clear and reset
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255));
            bus.clear = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
